nerv_wb_bridge: RTL and testbench

- Adapts a NERV-style fixed-latency core memory port (address/strobe in, data back, global stall) to a Wishbone classic master with real cyc/stb/ack handshaking.
- Sits between the core and the Controller bus, one instance per port: instruction port with READ_ONLY=1, data port with READ_ONLY=0.
- Drives the core stall while a bus cycle is outstanding, honours wait states and err, and aborts hung cycles with a timeout.

---
 rtl/nerv_wb_bridge.sv | 129 ++++++++++++
 tb/tb_nerv_wb_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nerv_wb_bridge.sv
// Bridges a NERV-style stalled memory port onto a Wishbone classic master.
// One request is accepted in IDLE, held on the bus until ack/err/timeout, then released for a single DONE cycle.
module nerv_wb_bridge #(
    parameter int unsigned             ADDR_WIDTH     = 32,
    parameter int unsigned             DATA_WIDTH     = 32,
    parameter bit                      READ_ONLY      = 1'b0,
    parameter int unsigned             TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0]   ERR_DATA       = '0,
    localparam int unsigned            SEL_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    input  logic                  core_req_valid,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [SEL_WIDTH-1:0]  core_wstrb,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [SEL_WIDTH-1:0]  wb_sel,
    output logic [ADDR_WIDTH-1:0] wb_adr,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    output logic                  bus_fault,
    output logic [15:0]           fault_count
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_e;

    state_e                  state_q;
    logic                    wb_cyc_q;
    logic                    wb_we_q;
    logic [SEL_WIDTH-1:0]    wb_sel_q;
    logic [ADDR_WIDTH-1:0]   wb_adr_q;
    logic [DATA_WIDTH-1:0]   wb_dat_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    bus_fault_q;
    logic [15:0]             fault_count_q;
    logic [15:0]             fault_count_d;
    logic [TW-1:0]           tmo_q;
    logic                    req_write;
    logic                    timeout_hit;
    logic                    fault_hit;

    always_comb begin
        req_write     = (|core_wstrb) & ~READ_ONLY;
        // Timeout only fires when the slave is silent; err still takes priority over ack.
        timeout_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST) && !wb_ack && !wb_err;
        fault_hit     = wb_err | timeout_hit;
        fault_count_d = (fault_count_q == '1) ? fault_count_q : fault_count_q + 16'd1;
        core_stall    = (state_q == BUS) | ((state_q == IDLE) & core_req_valid);
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q       <= IDLE;
            wb_cyc_q      <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_sel_q      <= '0;
            wb_adr_q      <= '0;
            wb_dat_q      <= '0;
            rdata_q       <= '0;
            bus_fault_q   <= 1'b0;
            fault_count_q <= '0;
            tmo_q         <= '0;
        end else begin
            bus_fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (core_req_valid) begin
                        wb_cyc_q <= 1'b1;
                        wb_we_q  <= req_write;
                        wb_sel_q <= req_write ? core_wstrb : '1;
                        wb_adr_q <= core_addr;
                        wb_dat_q <= READ_ONLY ? '0 : core_wdata;
                        tmo_q    <= '0;
                        state_q  <= BUS;
                    end
                end
                BUS: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (fault_hit) begin
                        wb_cyc_q      <= 1'b0;
                        wb_we_q       <= 1'b0;
                        rdata_q       <= ERR_DATA;
                        bus_fault_q   <= 1'b1;
                        fault_count_q <= fault_count_d;
                        state_q       <= DONE;
                    end else if (wb_ack) begin
                        wb_cyc_q <= 1'b0;
                        wb_we_q  <= 1'b0;
                        if (!wb_we_q) begin
                            rdata_q <= wb_dat_i;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wb_cyc      = wb_cyc_q;
    assign wb_stb      = wb_cyc_q;
    assign wb_we       = wb_we_q;
    assign wb_sel      = wb_sel_q;
    assign wb_adr      = wb_adr_q;
    assign wb_dat_o    = wb_dat_q;
    assign core_rdata  = rdata_q;
    assign bus_fault   = bus_fault_q;
    assign fault_count = fault_count_q;

endmodule

// File: tb/tb_nerv_wb_bridge.sv
// Scoreboard bench for nerv_wb_bridge: a data-port instance (short timeout) and a read-only instance.
module tb_nerv_wb_bridge;

    localparam logic [31:0] ERRD = 32'hBADC0DE5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req, stall, cyc, stb, we, ack, err, fault;
    logic [31:0] addr, wdata, rdata, adr, dato, dati;
    logic [3:0]  wstrb, sel;
    logic [15:0] fcnt;

    logic        ro_req, ro_stall, ro_cyc, ro_stb, ro_we, ro_ack, ro_err, ro_fault;
    logic [31:0] ro_addr, ro_wdata, ro_rdata, ro_adr, ro_dato, ro_dati;
    logic [3:0]  ro_wstrb, ro_sel;
    logic [15:0] ro_fcnt;

    nerv_wb_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_ONLY(1'b0),
        .TIMEOUT_CYCLES(8), .ERR_DATA(ERRD)
    ) u_dut (
        .clk_core(clk), .rst_core(rst), .core_req_valid(req), .core_addr(addr),
        .core_wstrb(wstrb), .core_wdata(wdata), .core_rdata(rdata), .core_stall(stall),
        .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_sel(sel), .wb_adr(adr),
        .wb_dat_o(dato), .wb_dat_i(dati), .wb_ack(ack), .wb_err(err),
        .bus_fault(fault), .fault_count(fcnt)
    );

    nerv_wb_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_ONLY(1'b1)
    ) u_ro (
        .clk_core(clk), .rst_core(rst), .core_req_valid(ro_req), .core_addr(ro_addr),
        .core_wstrb(ro_wstrb), .core_wdata(ro_wdata), .core_rdata(ro_rdata), .core_stall(ro_stall),
        .wb_cyc(ro_cyc), .wb_stb(ro_stb), .wb_we(ro_we), .wb_sel(ro_sel), .wb_adr(ro_adr),
        .wb_dat_o(ro_dato), .wb_dat_i(ro_dati), .wb_ack(ro_ack), .wb_err(ro_err),
        .bus_fault(ro_fault), .fault_count(ro_fcnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [15:0] fcnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_rdata;
    logic [15:0] m_fcnt;

    // Entered and left at a negedge with the DUT in IDLE.
    // mode: 0 = ack, 1 = err together with ack, 2 = silent slave (timeout)
    task automatic do_xfer(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                           input int waits, input int mode, input logic [31:0] rd, input bit hold);
        exp_t       e;
        int         bus_n;
        bit         done;
        logic       wr;
        logic [3:0] exp_sel;
        wr      = (ws != 4'h0);
        exp_sel = wr ? ws : 4'hF;
        if (mode != 0) begin
            m_rdata = ERRD;
            m_fcnt  = m_fcnt + 16'd1;
        end else if (!wr) begin
            m_rdata = rd;
        end
        e.rdata = m_rdata;
        e.fault = (mode != 0);
        e.fcnt  = m_fcnt;
        sb.push_back(e);

        req = 1'b1; addr = a; wstrb = ws; wdata = wd;
        #1;
        chk("stall_req", stall, 1);
        chk("cyc_idle", cyc, 0);
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        addr = ~a; wstrb = ~ws; wdata = ~wd;

        bus_n = 0;
        done  = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!cyc) begin
                done = 1;
            end else begin
                bus_n++;
                chk("adr", adr, a);
                chk("sel", sel, exp_sel);
                chk("we", we, wr);
                chk("stb", stb, 1);
                chk("stall_bus", stall, 1);
                if (wr) chk("dat_o", dato, wd);
                if (bus_n == waits + 1 && mode != 2) begin
                    ack  = 1'b1;
                    err  = (mode == 1);
                    dati = rd;
                end else begin
                    dati = $urandom;
                end
                @(posedge clk); #1;
                ack = 1'b0;
                err = 1'b0;
            end
        end
        chk("terminated", done, 1);
        chk("bus_cycles", bus_n, (mode == 2) ? 8 : waits + 1);

        chk("stall_done", stall, 0);
        e = sb.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("fault_pulse", fault, e.fault);
        chk("fault_count", fcnt, e.fcnt);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("fault_clr", fault, 0);
        chk("stall_idle", stall, 0);
        chk("cyc_after", cyc, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        req = 0; addr = '0; wstrb = '0; wdata = '0; ack = 0; err = 0; dati = '0;
        ro_req = 0; ro_addr = '0; ro_wstrb = '0; ro_wdata = '0; ro_ack = 0; ro_err = 0; ro_dati = '0;
        m_rdata = '0;
        m_fcnt  = '0;

        @(negedge clk);
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);
        chk("rst_sel", sel, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat_o", dato, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_stall", stall, 0);

        do_xfer(32'h100, 4'h0, 32'h0,        0, 0, 32'hDEADBEEF, 0);
        do_xfer(32'h204, 4'h2, 32'h0000AB00, 3, 0, 32'h11112222, 0);
        do_xfer(32'h308, 4'hF, 32'h12345678, 2, 0, 32'hA5A50001, 0);
        do_xfer(32'h40C, 4'h0, 32'h0,        1, 0, 32'h0BADF00D, 0);
        do_xfer(32'h500, 4'h0, 32'h0,        0, 1, 32'h77777777, 0);
        do_xfer(32'h604, 4'h1, 32'h000000FF, 0, 2, 32'h0,        0);
        do_xfer(32'h700, 4'h0, 32'h0,        0, 0, 32'h13579BDF, 0);
        do_xfer(32'h710, 4'hC, 32'hCDEF0000, 1, 1, 32'h0,        0);
        do_xfer(32'h720, 4'h0, 32'h0,        0, 2, 32'h0,        0);

        // Reset in the second BUS cycle; the request stays asserted across it.
        req = 1'b1; addr = 32'h800; wstrb = 4'h0; wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_cyc", cyc, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cyc", cyc, 0);
        chk("mid_rst_stb", stb, 0);
        chk("mid_rst_we", we, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_adr", adr, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_fcnt", fcnt, 0);
        chk("mid_rst_stall", stall, 1);
        @(negedge clk);
        rst = 1'b0;
        m_rdata = '0;
        m_fcnt  = '0;
        do_xfer(32'h800, 4'h0, 32'h0, 2, 0, 32'hFEEDFACE, 1);

        // Read-only port: a full strobe must still become a read.
        ro_req = 1'b1; ro_addr = 32'h40; ro_wstrb = 4'hF; ro_wdata = 32'h12345678;
        #1;
        chk("ro_stall_req", ro_stall, 1);
        @(posedge clk); #1;
        ro_req = 1'b0; ro_wstrb = 4'h0;
        @(negedge clk);
        chk("ro_cyc", ro_cyc, 1);
        chk("ro_we", ro_we, 0);
        chk("ro_sel", ro_sel, 4'hF);
        chk("ro_adr", ro_adr, 32'h40);
        ro_ack = 1'b1;
        ro_dati = 32'hCAFEF00D;
        @(posedge clk); #1;
        ro_ack = 1'b0;
        @(negedge clk);
        chk("ro_stall_done", ro_stall, 0);
        chk("ro_cyc_done", ro_cyc, 0);
        chk("ro_rdata", ro_rdata, 32'hCAFEF00D);
        chk("ro_fault", ro_fault, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
